// File: rtl/t_reg_bank.sv
// Parametrised bank of edge-triggered T-type cells with toggle, load and up/down count modes,
// a registered wrap pulse and a saturating count of edges on which the stored value changed.
module t_reg_bank #(
  parameter int                 WIDTH       = 8,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0,
  parameter int                 CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] t,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic             wrap,
  output logic [CNT_W-1:0] chg_cnt
);

  typedef enum logic [1:0] {
    MODE_TOGGLE = 2'b00,
    MODE_LOAD   = 2'b01,
    MODE_UP     = 2'b10,
    MODE_DOWN   = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [WIDTH-1:0] q_next;
  logic             wrap_next;
  logic [CNT_W-1:0] chg_next;
  logic             changed;

  // Next value of the bank; wrap is detected from the current value before the step.
  always_comb begin
    q_next    = q;
    wrap_next = 1'b0;
    if (en) begin
      case (mode_e'(mode))
        MODE_TOGGLE: q_next = q ^ t;
        MODE_LOAD:   q_next = d;
        MODE_UP: begin
          if (t[0]) begin
            q_next    = q + WIDTH'(1);
            wrap_next = (q == ALL_ONES);
          end
        end
        MODE_DOWN: begin
          if (t[0]) begin
            q_next    = q - WIDTH'(1);
            wrap_next = (q == '0);
          end
        end
        default: q_next = q;
      endcase
    end
  end

  // A change is an actual difference in value, so reloading q or toggling with t=0 is not counted.
  always_comb begin
    changed  = (q_next != q);
    chg_next = chg_cnt;
    if (changed && (chg_cnt != CNT_MAX)) begin
      chg_next = chg_cnt + CNT_W'(1);
    end
  end

  // Clear returns to the reset state but the clearing edge itself is never counted.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q       <= RESET_VALUE;
      wrap    <= 1'b0;
      chg_cnt <= '0;
    end else if (clr) begin
      q       <= RESET_VALUE;
      wrap    <= 1'b0;
      chg_cnt <= '0;
    end else begin
      q       <= q_next;
      wrap    <= wrap_next;
      chg_cnt <= chg_next;
    end
  end

  assign qb = ~q;

endmodule

// File: tb/tb_t_reg_bank.sv
// Directed self-checking bench for t_reg_bank: a default instance plus a CNT_W=2 instance
// sharing the same inputs, used for the change-counter saturation case.
module tb_t_reg_bank;

  logic       clk = 1'b0;
  logic       reset;
  logic       clr;
  logic       en;
  logic [1:0] mode;
  logic [7:0] t;
  logic [7:0] d;
  logic [7:0] q, qb, q2, qb2;
  logic       wrap, wrap2;
  logic [15:0] chg_cnt;
  logic [1:0]  chg_cnt2;

  int checks = 0;
  int errors = 0;

  t_reg_bank #(.WIDTH(8), .RESET_VALUE(8'h00), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .mode(mode), .t(t), .d(d),
    .q(q), .qb(qb), .wrap(wrap), .chg_cnt(chg_cnt)
  );

  t_reg_bank #(.WIDTH(8), .RESET_VALUE(8'h00), .CNT_W(2)) dut_sat (
    .clk(clk), .reset(reset), .clr(clr), .en(en), .mode(mode), .t(t), .d(d),
    .q(q2), .qb(qb2), .wrap(wrap2), .chg_cnt(chg_cnt2)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      clr  = 1'($urandom);
      en   = 1'($urandom);
      mode = 2'($urandom);
      t    = 8'($urandom);
      d    = 8'($urandom);
      tick();
    end
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL reset_q got %h exp %h", q, 8'h00); end
    checks++; if (qb !== 8'hFF) begin errors++; $display("FAIL reset_qb got %h exp %h", qb, 8'hFF); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b exp 0", wrap); end
    checks++; if (chg_cnt !== 16'd0) begin errors++; $display("FAIL reset_chg got %0d exp 0", chg_cnt); end
    clr = 1'b0; en = 1'b0; mode = 2'b00; t = 8'h00; d = 8'h00;
    reset = 1'b1;
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL post_reset_q got %h exp %h", q, 8'h00); end
  endtask

  task automatic test_toggle;
    en = 1'b1; mode = 2'b00;
    t = 8'h0F; tick();
    checks++; if (q !== 8'h0F) begin errors++; $display("FAIL toggle_0f_q got %h exp %h", q, 8'h0F); end
    t = 8'hFF; tick();
    checks++; if (q !== 8'hF0) begin errors++; $display("FAIL toggle_ff_q got %h exp %h", q, 8'hF0); end
    t = 8'h00; tick();
    checks++; if (q !== 8'hF0) begin errors++; $display("FAIL toggle_00_q got %h exp %h", q, 8'hF0); end
    checks++; if (qb !== 8'h0F) begin errors++; $display("FAIL toggle_qb got %h exp %h", qb, 8'h0F); end
    checks++; if (chg_cnt !== 16'd2) begin errors++; $display("FAIL toggle_chg got %0d exp 2", chg_cnt); end
    clr = 1'b1; tick(); clr = 1'b0;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL toggle_clr_q got %h exp %h", q, 8'h00); end
    checks++; if (chg_cnt !== 16'd0) begin errors++; $display("FAIL toggle_clr_chg got %0d exp 0", chg_cnt); end
  endtask

  task automatic test_load_count_up;
    en = 1'b1; mode = 2'b01; d = 8'hFE; tick();
    checks++; if (q !== 8'hFE) begin errors++; $display("FAIL load_fe_q got %h exp %h", q, 8'hFE); end
    mode = 2'b10; t = 8'h01; tick();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL up1_q got %h exp %h", q, 8'hFF); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL up1_wrap got %b exp 0", wrap); end
    tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL up2_q got %h exp %h", q, 8'h00); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL up2_wrap got %b exp 1", wrap); end
    tick();
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL up3_q got %h exp %h", q, 8'h01); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL up3_wrap got %b exp 0", wrap); end
    checks++; if (chg_cnt !== 16'd4) begin errors++; $display("FAIL up_chg got %0d exp 4", chg_cnt); end
  endtask

  task automatic test_count_down;
    en = 1'b1; mode = 2'b01; d = 8'h01; tick();
    checks++; if (chg_cnt !== 16'd4) begin errors++; $display("FAIL reload_same_chg got %0d exp 4", chg_cnt); end
    mode = 2'b11; t = 8'hFF; tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL down1_q got %h exp %h", q, 8'h00); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL down1_wrap got %b exp 0", wrap); end
    tick();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL down2_q got %h exp %h", q, 8'hFF); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL down2_wrap got %b exp 1", wrap); end
    t = 8'hFE; tick();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL down_hold_q got %h exp %h", q, 8'hFF); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL down_hold_wrap got %b exp 0", wrap); end
    checks++; if (chg_cnt !== 16'd6) begin errors++; $display("FAIL down_chg got %0d exp 6", chg_cnt); end
  endtask

  task automatic test_priority;
    en = 1'b0; mode = 2'b01; d = 8'hAA; tick();
    checks++; if (q !== 8'hFF) begin errors++; $display("FAIL en0_q got %h exp %h", q, 8'hFF); end
    checks++; if (chg_cnt !== 16'd6) begin errors++; $display("FAIL en0_chg got %0d exp 6", chg_cnt); end
    en = 1'b1; clr = 1'b1; tick();
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL clr_q got %h exp %h", q, 8'h00); end
    checks++; if (chg_cnt !== 16'd0) begin errors++; $display("FAIL clr_chg got %0d exp 0", chg_cnt); end
    clr = 1'b0; d = 8'h55; tick();
    checks++; if (q !== 8'h55) begin errors++; $display("FAIL load_55_q got %h exp %h", q, 8'h55); end
    clr = 1'b1; reset = 1'b0; #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL clr_reset_q got %h exp %h", q, 8'h00); end
    checks++; if (chg_cnt !== 16'd0) begin errors++; $display("FAIL clr_reset_chg got %0d exp 0", chg_cnt); end
    tick();
    reset = 1'b1; clr = 1'b0; en = 1'b0;
    tick();
  endtask

  task automatic test_async_reset;
    en = 1'b1; mode = 2'b01; d = 8'h10; tick();
    mode = 2'b10; t = 8'h01; tick();
    checks++; if (q !== 8'h11) begin errors++; $display("FAIL pre_async_q got %h exp %h", q, 8'h11); end
    #2 reset = 1'b0;
    #1;
    checks++; if (q !== 8'h00) begin errors++; $display("FAIL async_q got %h exp %h", q, 8'h00); end
    checks++; if (qb !== 8'hFF) begin errors++; $display("FAIL async_qb got %h exp %h", qb, 8'hFF); end
    checks++; if (chg_cnt !== 16'd0) begin errors++; $display("FAIL async_chg got %0d exp 0", chg_cnt); end
    tick();
    en = 1'b0; reset = 1'b1;
    tick();
  endtask

  task automatic test_saturation;
    logic [1:0] exp_sat [5];
    exp_sat[0] = 2'd1; exp_sat[1] = 2'd2; exp_sat[2] = 2'd3; exp_sat[3] = 2'd3; exp_sat[4] = 2'd3;
    en = 1'b1; mode = 2'b00; t = 8'h01;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (chg_cnt2 !== exp_sat[i]) begin errors++; $display("FAIL sat_chg[%0d] got %0d exp %0d", i, chg_cnt2, exp_sat[i]); end
    end
    checks++; if (q !== 8'h01) begin errors++; $display("FAIL sat_q got %h exp %h", q, 8'h01); end
    checks++; if (chg_cnt !== 16'd5) begin errors++; $display("FAIL sat_wide_chg got %0d exp 5", chg_cnt); end
    t = 8'h00; tick();
    checks++; if (chg_cnt !== 16'd5) begin errors++; $display("FAIL toggle_zero_chg got %0d exp 5", chg_cnt); end
    checks++; if (chg_cnt2 !== 2'd3) begin errors++; $display("FAIL sat_hold_chg got %0d exp 3", chg_cnt2); end
  endtask

  initial begin
    reset = 1'b0; clr = 1'b0; en = 1'b0; mode = 2'b00; t = 8'h00; d = 8'h00;
    test_reset();
    test_toggle();
    test_load_count_up();
    test_count_down();
    test_priority();
    test_async_reset();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/t_reg_bank.md
# t_reg_bank

Parametrised, edge-triggered bank of T-type storage cells: WIDTH bits, each with its own toggle input, plus load, up-count and down-count modes. It is the registered, multi-bit successor to the single-bit T latch and serves as a general toggle, load or count register in the sequential library. It also provides a wrap flag and a saturating count of the clock edges on which the stored value changed.

## Interface
Parameters:
- WIDTH, 8, number of storage bits (≥1)
- RESET_VALUE, 0, value of q after reset or clear (WIDTH bits)
- CNT_W, 16, width of the change counter (≥2)

Ports:
- clk  input  1  clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- clr  input  1  synchronous clear; highest priority after reset
- en  input  1  operation enable; when 0, q holds
- mode  input  2  00 TOGGLE, 01 LOAD, 10 COUNT_UP, 11 COUNT_DOWN
- t  input  WIDTH  per-bit toggle mask (TOGGLE); t[0] is the count enable (COUNT modes)
- d  input  WIDTH  load data (LOAD)
- q  output  WIDTH  stored value
- qb  output  WIDTH  ~q, combinational
- wrap  output  1  registered one-cycle pulse on count wrap-around
- chg_cnt  output  CNT_W  saturating count of edges on which q changed

## Operation
- Reset is asserted while reset=0, regardless of clk. During reset: q=RESET_VALUE, qb=~RESET_VALUE, wrap=0, chg_cnt=0.
- Priority at each rising edge: clr, then en, then mode.
- clr=1: q<=RESET_VALUE, wrap<=0, chg_cnt<=0. A change in q caused by clr is not counted.
- en=0 (clr=0): q holds, wrap<=0, chg_cnt holds.
- en=1, TOGGLE: q<=q^t. Bits with t=0 hold. wrap<=0.
- en=1, LOAD: q<=d. wrap<=0.
- en=1, COUNT_UP:
  - t[0]=1: q<=q+1, modulo 2^WIDTH. wrap<=1 only on the edge where q goes from all-ones to 0.
  - t[0]=0: q holds, wrap<=0.
  - t[WIDTH-1:1] is ignored.
- en=1, COUNT_DOWN:
  - t[0]=1: q<=q-1, modulo 2^WIDTH. wrap<=1 only on the edge where q goes from 0 to all-ones.
  - t[0]=0: q holds, wrap<=0.
- chg_cnt: on any non-clr edge where the next q differs from the current q, chg_cnt<=chg_cnt+1. It saturates at 2^CNT_W-1 and never wraps. A load of the current value, or a TOGGLE with t=0, is not a change.
- WIDTH=1: COUNT_UP and COUNT_DOWN both behave as toggle-by-t[0]. wrap fires on 1->0 (up) and on 0->1 (down).

## Timing
- q, wrap and chg_cnt update on the rising clk edge, one-cycle latency from inputs.
- qb is combinational from q. There are no other combinational input-to-output paths.
- wrap is high for exactly the one cycle in which q shows the wrapped value.
- Reset deassertion (0->1) is synchronised by the integrator. The first state update is on the first rising edge with reset=1.
- Reset asserted mid-count: outputs go to reset values immediately, without waiting for a clock edge.

## Test plan
- Reset: hold reset=0 with clk running and inputs random -> q=RESET_VALUE, qb=~RESET_VALUE, wrap=0, chg_cnt=0. Assert reset between edges -> outputs clear immediately.
- Toggle mask, WIDTH=8, RESET_VALUE=0, en=1, mode=00:
  - t=8'h0F -> q=8'h0F
  - t=8'hFF -> q=8'hF0
  - t=8'h00 -> q=8'hF0, chg_cnt=2
- Load then count up: LOAD d=8'hFE, then COUNT_UP with t[0]=1 for 3 edges -> q=FF, 00, 01. wrap=1 only in the cycle q=00. chg_cnt=4.
- Count down and count enable:
  - LOAD d=8'h01, COUNT_DOWN t[0]=1 for 2 edges -> q=00, then FF with wrap=1.
  - Set t[0]=0 -> q holds FF, wrap=0.
- Enable and clear priority:
  - en=0 with mode=01, d=8'hAA -> q unchanged.
  - clr=1 with en=1, mode=01 -> q=RESET_VALUE, chg_cnt=0.
  - clr and reset asserted together -> reset values.
- Saturation: CNT_W=2, toggle t=8'h01 for 5 edges -> chg_cnt=1, 2, 3, 3, 3.
